// File: rtl/mapper_mem_sequencer.sv
// mapper_mem_sequencer: turns mapper read strobes into SDRAM req/ack reads with a one-entry cache and timeout
module mapper_mem_sequencer #(
    parameter int ADDR_W   = 27,
    parameter int TIMEOUT  = 255,
    parameter int CACHE_EN = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ram_cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              invalidate,
    output logic              cpu_wait,
    output logic [7:0]        cpu_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_q, state_d;
    logic              ram_cs_q, ram_cs_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        cpu_data_q, cpu_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [7:0]        cache_data_q, cache_data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              start, hit;

    always_comb begin
        start         = ram_cs & ~ram_cs_q;
        hit           = (CACHE_EN != 0) & cache_valid_q & (addr == cache_addr_q) & ~invalidate;
        state_d       = state_q;
        ram_cs_d      = ram_cs;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        cpu_data_d    = cpu_data_q;
        timeout_err_d = 1'b0;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (start && hit) begin
                    cpu_data_d = cache_data_q;
                    state_d    = DONE;
                end else if (start) begin
                    mem_addr_d = addr;
                    mem_req_d  = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                // ack wins over a timeout landing in the same cycle
                if (mem_ack) begin
                    cpu_data_d    = mem_rdata;
                    mem_req_d     = 1'b0;
                    cache_addr_d  = mem_addr_q;
                    cache_data_d  = mem_rdata;
                    cache_valid_d = 1'b1;
                    state_d       = ram_cs ? DONE : IDLE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    mem_req_d     = 1'b0;
                    cpu_data_d    = 8'hFF;
                    timeout_err_d = 1'b1;
                    state_d       = ram_cs ? DONE : IDLE;
                end
            end
            DONE:    state_d = ram_cs ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        if (invalidate) cache_valid_d = 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ram_cs_q      <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            cpu_data_q    <= 8'hFF;
            timeout_err_q <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= 8'h00;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            ram_cs_q      <= ram_cs_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            cpu_data_q    <= cpu_data_d;
            timeout_err_q <= timeout_err_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            cnt_q         <= cnt_d;
        end
    end

    assign cpu_wait    = (state_q == ISSUE) | ((state_q == IDLE) & start & ~hit);
    assign cpu_data    = cpu_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_mapper_mem_sequencer.sv
// tb_mapper_mem_sequencer: per-cycle vector table on a cached TIMEOUT=8 instance plus a hand sequence on an uncached one
module tb_mapper_mem_sequencer;
    localparam logic [26:0] A = 27'h0004123;
    localparam logic [26:0] B = 27'h0001000;
    localparam logic [26:0] C = 27'h0200000;
    localparam logic [26:0] D = 27'h0000ABC;

    typedef struct {
        logic        rst_n, cs;
        logic [26:0] addr;
        logic        inv, ack;
        logic [7:0]  rdata;
        logic        w, r;
        logic [26:0] ma;
        logic [7:0]  d;
        logic        te;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0, ram_cs = 1'b0, invalidate = 1'b0, mem_ack = 1'b0;
    logic [26:0] addr = '0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cpu_wait, mem_req, timeout_err;
    logic [7:0]  cpu_data;
    logic [26:0] mem_addr;

    logic        rst2_n = 1'b0, cs2 = 1'b0, ack2 = 1'b0;
    logic [26:0] addr2 = '0;
    logic [7:0]  rdata2 = 8'h00;
    logic        wait2, req2, terr2;
    logic [7:0]  data2;
    logic [26:0] maddr2;

    mapper_mem_sequencer #(.ADDR_W(27), .TIMEOUT(8), .CACHE_EN(1)) dut (
        .clk_sys(clk), .reset_n(reset_n), .ram_cs(ram_cs), .addr(addr), .invalidate(invalidate),
        .cpu_wait(cpu_wait), .cpu_data(cpu_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
    );

    mapper_mem_sequencer #(.ADDR_W(27), .TIMEOUT(255), .CACHE_EN(0)) dut_nc (
        .clk_sys(clk), .reset_n(rst2_n), .ram_cs(cs2), .addr(addr2), .invalidate(1'b0),
        .cpu_wait(wait2), .cpu_data(data2), .mem_req(req2), .mem_addr(maddr2),
        .mem_ack(ack2), .mem_rdata(rdata2), .timeout_err(terr2)
    );

    int checks = 0, errors = 0;
    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst_n, cs, input logic [26:0] a, input logic inv, ack,
                       input logic [7:0] rd, input logic w, r, input logic [26:0] ma,
                       input logic [7:0] d, input logic te);
        vq.push_back('{rst_n: rst_n, cs: cs, addr: a, inv: inv, ack: ack, rdata: rd,
                       w: w, r: r, ma: ma, d: d, te: te});
    endtask

    initial begin
        // miss, ack in third request cycle: four wait cycles
        add(1,0,A,0,0,8'h00, 0,0,27'h0,8'hFF,0);
        add(1,1,A,0,0,8'h00, 1,0,27'h0,8'hFF,0);
        add(1,1,A,0,0,8'h00, 1,1,A,8'hFF,0);
        add(1,1,A,0,0,8'h00, 1,1,A,8'hFF,0);
        add(1,1,A,0,1,8'h5A, 1,1,A,8'hFF,0);
        add(1,1,A,0,0,8'h00, 0,0,A,8'h5A,0);
        add(1,0,A,0,0,8'h00, 0,0,A,8'h5A,0);
        // repeat read hits
        add(1,1,A,0,0,8'h00, 0,0,A,8'h5A,0);
        add(1,1,A,0,0,8'h00, 0,0,A,8'h5A,0);
        add(1,0,A,0,0,8'h00, 0,0,A,8'h5A,0);
        // invalidate between reads
        add(1,0,A,1,0,8'h00, 0,0,A,8'h5A,0);
        add(1,1,A,0,0,8'h00, 1,0,A,8'h5A,0);
        add(1,1,A,0,1,8'hA5, 1,1,A,8'h5A,0);
        add(1,0,A,0,0,8'h00, 0,0,A,8'hA5,0);
        // invalidate coincident with ack blocks the fill
        add(1,1,B,0,0,8'h00, 1,0,A,8'hA5,0);
        add(1,1,B,1,1,8'h77, 1,1,B,8'hA5,0);
        add(1,0,B,0,0,8'h00, 0,0,B,8'h77,0);
        add(1,1,B,0,0,8'h00, 1,0,B,8'h77,0);
        add(1,1,B,0,1,8'h78, 1,1,B,8'h77,0);
        add(1,0,B,0,0,8'h00, 0,0,B,8'h78,0);
        // invalidate on the start cycle forces a miss
        add(1,1,B,1,0,8'h00, 1,0,B,8'h78,0);
        add(1,1,B,0,1,8'h79, 1,1,B,8'h78,0);
        add(1,0,B,0,0,8'h00, 0,0,B,8'h79,0);
        // timeout: request held exactly 8 cycles
        add(1,1,C,0,0,8'h00, 1,0,B,8'h79,0);
        for (int i = 0; i < 8; i++) add(1,1,C,0,0,8'h00, 1,1,C,8'h79,0);
        add(1,1,C,0,0,8'h00, 0,0,C,8'hFF,1);
        add(1,1,C,0,0,8'h00, 0,0,C,8'hFF,0);
        add(1,0,C,0,0,8'h00, 0,0,C,8'hFF,0);
        add(1,1,B,0,0,8'h00, 0,0,C,8'hFF,0);
        add(1,0,B,0,0,8'h00, 0,0,C,8'h79,0);
        // ram_cs dropped during ISSUE
        add(1,1,D,0,0,8'h00, 1,0,C,8'h79,0);
        for (int i = 0; i < 4; i++) add(1,0,D,0,0,8'h00, 1,1,D,8'h79,0);
        add(1,0,D,0,1,8'h33, 1,1,D,8'h79,0);
        add(1,0,D,0,0,8'h00, 0,0,D,8'h33,0);
        add(1,1,D,0,0,8'h00, 0,0,D,8'h33,0);
        add(1,0,D,0,0,8'h00, 0,0,D,8'h33,0);
        // reset mid-ISSUE, late ack ignored, cache cleared
        add(1,1,C,0,0,8'h00, 1,0,D,8'h33,0);
        add(0,1,C,0,0,8'h00, 1,1,C,8'h33,0);
        add(1,0,C,0,1,8'h99, 0,0,27'h0,8'hFF,0);
        add(1,0,C,0,0,8'h00, 0,0,27'h0,8'hFF,0);
        add(1,1,D,0,0,8'h00, 1,0,27'h0,8'hFF,0);
        add(1,1,D,0,1,8'h44, 1,1,D,8'hFF,0);
        add(1,0,D,0,0,8'h00, 0,0,D,8'h44,0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset_n = vq[i].rst_n; ram_cs = vq[i].cs; addr = vq[i].addr;
            invalidate = vq[i].inv; mem_ack = vq[i].ack; mem_rdata = vq[i].rdata;
            #1;
            chk($sformatf("v%0d_wait", i), 32'(cpu_wait), 32'(vq[i].w));
            chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(vq[i].r));
            chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vq[i].ma));
            chk($sformatf("v%0d_data", i), 32'(cpu_data), 32'(vq[i].d));
            chk($sformatf("v%0d_terr", i), 32'(timeout_err), 32'(vq[i].te));
        end

        // uncached instance: a repeat read still goes to memory
        @(negedge clk); rst2_n = 1'b1; #1;
        chk("nc_reset_data", 32'(data2), 32'hFF);
        @(negedge clk); cs2 = 1'b1; addr2 = A; #1;
        chk("nc_first_wait", 32'(wait2), 32'd1);
        @(negedge clk); #1;
        chk("nc_first_req", 32'(req2), 32'd1);
        chk("nc_first_maddr", 32'(maddr2), 32'(A));
        ack2 = 1'b1; rdata2 = 8'h5A;
        @(negedge clk); ack2 = 1'b0; #1;
        chk("nc_first_data", 32'(data2), 32'h5A);
        chk("nc_first_done_wait", 32'(wait2), 32'd0);
        @(negedge clk); cs2 = 1'b0;
        @(negedge clk); cs2 = 1'b1; #1;
        chk("nc_second_wait", 32'(wait2), 32'd1);
        @(negedge clk); #1;
        chk("nc_second_req", 32'(req2), 32'd1);
        ack2 = 1'b1; rdata2 = 8'h66;
        @(negedge clk); ack2 = 1'b0; cs2 = 1'b0; #1;
        chk("nc_second_data", 32'(data2), 32'h66);
        chk("nc_second_req_drop", 32'(req2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
